cpu_mem_arb: RTL and testbench
==============================

Name: cpu_mem_arb

Overview:
- Shares one memory bus port between the instruction-fetch path (PC/fetch stage) and the data (load/store) path of the CPU.
- Allows one outstanding bus transaction at a time. Data has priority, bounded by an anti-starvation counter so fetch always makes progress.
- Grant and acknowledge are registered, so the pipeline's stall logic sees clean, single-cycle acks.
- Sits between the CPU core (fetch and execute units) and the external memory/cache bus.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while ifetch_req is pending; the next grant goes to fetch.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- ifetch_req  in  1  fetch request; level, held until ifetch_ack
- ifetch_addr  in  32  fetch byte address; bits [1:0] ignored
- ifetch_ack  out  1  one-cycle pulse; ifetch_rdata valid this cycle
- ifetch_rdata  out  32  fetched instruction word
- data_req  in  1  load/store request; level, held until data_ack
- data_write  in  1  1 = store, 0 = load
- data_addr  in  32  data byte address
- data_wdata  in  32  store data
- data_wstrb  in  4  byte enables for stores
- data_ack  out  1  one-cycle pulse; data_rdata valid for loads
- data_rdata  out  32  load data
- mem_req  out  1  bus request; held until mem_ack
- mem_write  out  1  bus write flag
- mem_addr  out  32  bus address, word aligned ([1:0] forced to 0)
- mem_wdata  out  32  bus write data
- mem_wstrb  out  4  bus byte enables; 4'hf for fetch
- mem_ack  in  1  bus completion; mem_rdata valid same cycle
- mem_rdata  in  32  bus read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (reset_n low at a clock edge):
  - state = IDLE, starvation count = 0.
  - All outputs = 0: mem_req, acks, rdata, mem_addr, mem_wdata, mem_wstrb, mem_write.
- IDLE: arbitrate at the clock edge.
  - Data wins if data_req && !(ifetch_req && count == STARVE_LIMIT).
  - Otherwise fetch wins if ifetch_req.
  - Otherwise stay IDLE.
- Grant at edge N:
  - Winner's addr, wdata, wstrb and write are registered onto the mem_* outputs.
  - mem_req = 1 from cycle N+1. Next state is BUSY_D or BUSY_I.
  - Fetch grant drives mem_write = 0 and mem_wstrb = 4'hf.
- Starvation count:
  - Data grant with ifetch_req high: count + 1, saturating at STARVE_LIMIT.
  - Fetch grant, or IDLE with ifetch_req low: count = 0.
- BUSY_x: mem_* outputs held stable until mem_ack.
  - On the edge where mem_ack = 1: mem_req = 0, state = IDLE.
  - Requester's ack = 1 for exactly the next cycle, with rdata = mem_rdata registered.
- Acks: never both asserted in one cycle.
  - rdata holds its last value when the ack is low.
  - data_rdata is updated for stores too, and is don't-care.
- Timing:
  - Minimum latency: request seen at edge N, mem_req high N+1..M, mem_ack at M, requester ack at M+1.
  - A new arbitration happens at edge M+1 (state is IDLE during cycle M+1), so mem_req is low for at least one cycle between transactions.
- Requester pulses its ack while its req is still high. A requester sampling its own ack must drop or change its request that same cycle, or the re-evaluated request is granted again at the following edge.
- Request dropped before grant: treated as cancelled, no bus activity.
- Request dropped after grant: the transaction still completes and the ack still pulses; the requester ignores it.
- mem_ack while IDLE (e.g. a late ack after reset): ignored, no ack generated.
- Reset mid-transaction: aborts immediately to the reset state. A bus-side ack arriving after reset is ignored per the previous rule.
- Requests with reset_n low are not arbitrated.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding localparams (ST_IDLE = 0, ST_BUSY_I = 1, ST_BUSY_D = 2);
  - the FETCH_WSTRB = 4'hf constant.
- No sub-module: a single FSM plus one counter. An optional arbitration-decision function lives inside the module.

Test Plan:
- Lone fetch: ifetch_req = 1, addr = 0xffff0000; bus acks 2 cycles after mem_req with rdata 0x12345678 -> mem_addr = 0xffff0000, mem_wstrb = f, ifetch_ack pulses once with rdata 0x12345678, data_ack stays 0.
- Simultaneous requests: ifetch_req and data_req rise together, data store to 0x100 wdata 0xdeadbeef wstrb 0x3 -> first bus transaction is the store (mem_write = 1, wstrb = 3), then the fetch.
- Starvation: data_req held continuously, ifetch_req held, zero-wait bus -> exactly 4 data grants, then 1 fetch grant, repeating.
- Cancel: data_req high for one cycle while BUSY_I -> no data transaction after the fetch completes, data_ack never asserted.
- Reset mid-op: reset_n low while BUSY_D with mem_req = 1 -> next cycle mem_req = 0, state IDLE. A mem_ack arriving afterwards produces no ack.
- Address alignment: fetch addr 0x00000103 -> mem_addr = 0x00000100.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the CPU memory-bus arbiter.
// State encoding, state enum and the fetch byte-enable constant.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  localparam logic [3:0] FETCH_WSTRB = 4'hf;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_I = ST_BUSY_I,
    BUSY_D = ST_BUSY_D
  } arb_state_e;

endpackage

// File: rtl/cpu_mem_arb.sv
// cpu_mem_arb: shares one memory bus between instruction fetch and
// load/store, one transaction in flight, data-first with starvation bound.
//
// Ports:
//   clock, reset_n          clock, synchronous active-low reset
//   ifetch_req/addr         fetch request (level) and byte address
//   ifetch_ack/rdata        one-cycle fetch completion and instruction
//   data_req/write/addr     load/store request, direction, byte address
//   data_wdata/wstrb        store data and byte enables
//   data_ack/rdata          one-cycle data completion and load data
//   mem_req/write/addr      bus request (held until mem_ack), direction,
//   mem_wdata/wstrb         word-aligned address, write data, enables
//   mem_ack/rdata           bus completion and read data (same cycle)
module cpu_mem_arb
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        ifetch_ack,
  output logic [31:0] ifetch_rdata,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [31:0] AMASK = ~32'h3;

  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mreq_q, mreq_d;
  logic        mwr_q, mwr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [3:0]  mwstrb_q, mwstrb_d;
  logic        iack_q, iack_d;
  logic        dack_q, dack_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic data_win;
  logic fetch_win;

  // Data goes first unless fetch has been passed over LIMIT times.
  function automatic logic data_wins(
    input logic             dreq,
    input logic             ireq,
    input logic [CNT_W-1:0] cnt
  );
    return dreq && !(ireq && cnt == LIMIT);
  endfunction

  assign data_win  = data_wins(data_req, ifetch_req, cnt_q);
  assign fetch_win = ifetch_req && !data_win;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mreq_d   = mreq_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstrb_d = mwstrb_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    irdata_d = irdata_q;
    drdata_d = drdata_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          data_win: begin
            state_d  = BUSY_D;
            mreq_d   = 1'b1;
            mwr_d    = data_write;
            maddr_d  = data_addr & AMASK;
            mwdata_d = data_wdata;
            mwstrb_d = data_wstrb;
          end
          fetch_win: begin
            state_d  = BUSY_I;
            mreq_d   = 1'b1;
            mwr_d    = 1'b0;
            maddr_d  = ifetch_addr & AMASK;
            mwdata_d = 32'h0;
            mwstrb_d = FETCH_WSTRB;
          end
          default: ;
        endcase
        // Only a data grant over a waiting fetch counts toward starvation.
        if (data_win && ifetch_req)
          cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
        else
          cnt_d = '0;
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          iack_d   = 1'b1;
          irdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          dack_d   = 1'b1;
          drdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mreq_q   <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwstrb_q <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mreq_q   <= mreq_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstrb_q <= mwstrb_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign mem_req      = mreq_q;
  assign mem_write    = mwr_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = mwdata_q;
  assign mem_wstrb    = mwstrb_q;
  assign ifetch_ack   = iack_q;
  assign data_ack     = dack_q;
  assign ifetch_rdata = irdata_q;
  assign data_rdata   = drdata_q;

endmodule

// File: tb/tb_cpu_mem_arb.sv
// tb_cpu_mem_arb: directed bench for cpu_mem_arb.
// Simple bus responder with programmable wait, transaction log.
module tb_cpu_mem_arb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_ack;
  logic [31:0] ifetch_rdata;
  logic        data_req;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          total = 0;
  int          bad = 0;
  int          bus_wait = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  int          n_iack = 0;
  int          n_dack = 0;
  int          n_both = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;
  txn_t log_q[$];

  cpu_mem_arb dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ifetch_req  (ifetch_req),
    .ifetch_addr (ifetch_addr),
    .ifetch_ack  (ifetch_ack),
    .ifetch_rdata(ifetch_rdata),
    .data_req    (data_req),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_wstrb  (data_wstrb),
    .data_ack    (data_ack),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_ack = ack_force | (mem_req && wcnt == bus_wait);
  assign mem_rdata = bus_rdata;

  always @(posedge clock) begin
    if (!reset_n || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (reset_n && mem_req && mem_ack)
      log_q.push_back('{mem_write, mem_addr, mem_wdata, mem_wstrb});
    if (ifetch_ack) n_iack <= n_iack + 1;
    if (data_ack) n_dack <= n_dack + 1;
    if (ifetch_ack && data_ack) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for the selected ack, drops that request in the ack cycle.
  task automatic wait_ack(input string tag, input bit dsel,
                          output int lat);
    bit found = 1'b0;
    lat = 0;
    while (!found && lat < 50) begin
      tick();
      lat++;
      if (dsel ? data_ack : ifetch_ack) begin
        found = 1'b1;
        if (dsel) data_req = 1'b0;
        else ifetch_req = 1'b0;
      end
    end
    chk({tag, "_done"}, 32'(found), 32'd1);
  endtask

  initial begin
    int lat;
    int i0, d0;
    reset_n     = 1'b0;
    ifetch_req  = 1'b0;
    ifetch_addr = 32'h0;
    data_req    = 1'b0;
    data_write  = 1'b0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    data_wstrb  = 4'h0;

    // reset state
    tick();
    tick();
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_iack", 32'(ifetch_ack), 32'd0);
    chk("rst_dack", 32'(data_ack), 32'd0);
    chk("rst_irdata", ifetch_rdata, 32'h0);
    chk("rst_drdata", data_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    chk("rst_mwstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_mwrite", 32'(mem_write), 32'd0);
    reset_n = 1'b1;
    tick();

    // lone fetch, bus acks two cycles after mem_req rises
    i0 = n_iack;
    d0 = n_dack;
    bus_wait    = 2;
    bus_rdata   = 32'h12345678;
    ifetch_addr = 32'hffff0000;
    ifetch_req  = 1'b1;
    tick();
    chk("lf_mreq", 32'(mem_req), 32'd1);
    chk("lf_maddr", mem_addr, 32'hffff0000);
    chk("lf_wstrb", 32'(mem_wstrb), 32'hf);
    chk("lf_write", 32'(mem_write), 32'd0);
    wait_ack("lf", 1'b0, lat);
    chk("lf_lat", 32'(lat), 32'd3);
    chk("lf_rdata", ifetch_rdata, 32'h12345678);
    tick();
    chk("lf_ack_pulse", 32'(ifetch_ack), 32'd0);
    chk("lf_mreq_gap", 32'(mem_req), 32'd0);
    tick();
    tick();
    chk("lf_iack_cnt", 32'(n_iack - i0), 32'd1);
    chk("lf_dack_cnt", 32'(n_dack - d0), 32'd0);

    // simultaneous: store wins, then fetch
    log_q.delete();
    bus_wait    = 1;
    ifetch_addr = 32'h00000200;
    data_addr   = 32'h00000100;
    data_write  = 1'b1;
    data_wdata  = 32'hdeadbeef;
    data_wstrb  = 4'h3;
    ifetch_req  = 1'b1;
    data_req    = 1'b1;
    wait_ack("sim_d", 1'b1, lat);
    wait_ack("sim_i", 1'b0, lat);
    tick();
    tick();
    chk("sim_n", 32'(log_q.size()), 32'd2);
    chk("sim0_w", 32'(log_q[0].w), 32'd1);
    chk("sim0_a", log_q[0].a, 32'h00000100);
    chk("sim0_d", log_q[0].d, 32'hdeadbeef);
    chk("sim0_s", 32'(log_q[0].s), 32'h3);
    chk("sim1_w", 32'(log_q[1].w), 32'd0);
    chk("sim1_a", log_q[1].a, 32'h00000200);
    chk("sim1_s", 32'(log_q[1].s), 32'hf);

    // starvation: both held, zero-wait bus -> D D D D I repeating
    log_q.delete();
    bus_wait    = 0;
    data_write  = 1'b0;
    data_addr   = 32'h00000400;
    data_wstrb  = 4'h0;
    ifetch_addr = 32'h00000800;
    data_req    = 1'b1;
    ifetch_req  = 1'b1;
    repeat (24) tick();
    data_req   = 1'b0;
    ifetch_req = 1'b0;
    repeat (4) tick();
    chk("stv_n", 32'(log_q.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++)
      chk($sformatf("stv_a%0d", k), log_q[k].a,
          (k % 5 == 4) ? 32'h00000800 : 32'h00000400);

    // cancel: one-cycle data_req while fetch is in flight
    log_q.delete();
    d0 = n_dack;
    bus_wait    = 3;
    ifetch_addr = 32'h00000300;
    ifetch_req  = 1'b1;
    tick();
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    wait_ack("cxl", 1'b0, lat);
    repeat (6) tick();
    chk("cxl_n", 32'(log_q.size()), 32'd1);
    chk("cxl_a", log_q[0].a, 32'h00000300);
    chk("cxl_dack", 32'(n_dack - d0), 32'd0);

    // reset while a load is on the bus, then a stray mem_ack
    d0 = n_dack;
    i0 = n_iack;
    bus_wait  = 7;
    data_addr = 32'h00000500;
    data_req  = 1'b1;
    tick();
    chk("rmo_mreq", 32'(mem_req), 32'd1);
    data_req = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rmo_mreq0", 32'(mem_req), 32'd0);
    chk("rmo_maddr", mem_addr, 32'h0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    chk("rmo_dack", 32'(data_ack), 32'd0);
    chk("rmo_iack", 32'(ifetch_ack), 32'd0);
    chk("rmo_mreq1", 32'(mem_req), 32'd0);
    tick();
    tick();
    chk("rmo_dcnt", 32'(n_dack - d0), 32'd0);
    chk("rmo_icnt", 32'(n_iack - i0), 32'd0);

    // address alignment on fetch
    bus_wait    = 0;
    bus_rdata   = 32'h0badf00d;
    ifetch_addr = 32'h00000103;
    ifetch_req  = 1'b1;
    tick();
    chk("aln_maddr", mem_addr, 32'h00000100);
    wait_ack("aln", 1'b0, lat);
    chk("aln_rdata", ifetch_rdata, 32'h0badf00d);
    tick();

    // plain load returns bus data
    bus_rdata  = 32'hcafef00d;
    data_write = 1'b0;
    data_addr  = 32'h00000602;
    data_req   = 1'b1;
    tick();
    chk("ld_maddr", mem_addr, 32'h00000600);
    wait_ack("ld", 1'b1, lat);
    chk("ld_rdata", data_rdata, 32'hcafef00d);
    tick();

    chk("both_acks", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
